// File: rtl/score_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a multiplexed
// 4-digit common-anode 7-segment display with optional leading-zero blanking.
module score_display #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [13:0] Score,
  input  logic        Load,
  input  logic        Blank,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] BcdOut,
  output logic [6:0]  Seg,
  output logic [3:0]  DigitEn,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [13:0] value_q, value_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_out_q, bcd_out_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  digit_en_q, digit_en_d;

  logic [15:0] bcd_adj;
  logic [3:0]  sel_nib;
  logic        lz;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_out_d = bcd_out_q;
    case (state_q)
      S_IDLE: begin
        if (Load) begin
          value_d = (Score > 14'd9999) ? 14'd9999 : Score;
          bcd_d   = '0;
          cnt_d   = 4'd14;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_d, value_d} = {bcd_adj[14:0], value_q, 1'b0};
        cnt_d = cnt_q - 4'd1;
        // Result lands in BcdOut together with Done on the last shift.
        if (cnt_q == 4'd1) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          bcd_out_d = {bcd_adj[14:0], value_q[13]};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (presc_q >= PRESC_MAX) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
    end

    sel_nib = bcd_out_q[4*idx_q +: 4];
    case (idx_q)
      2'd1:    lz = (bcd_out_q[15:4] == 12'h000);
      2'd2:    lz = (bcd_out_q[15:8] == 8'h00);
      2'd3:    lz = (bcd_out_q[15:12] == 4'h0);
      default: lz = 1'b0;
    endcase

    seg_d      = (BLANK_LZ && lz) ? 7'h7F : seg_decode(sel_nib);
    digit_en_d = Blank ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      value_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_out_q  <= '0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      digit_en_q <= 4'hF;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      value_q    <= value_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_out_q  <= bcd_out_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign BcdOut    = bcd_out_q;
  assign Seg       = seg_q;
  assign DigitEn   = digit_en_q;
  assign dbg_state = state_q;

endmodule
